// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - true dual-port synchronous RAM with write-collision flag
//
// Ports:
//   clk0              shared clock, all state changes on rising edge
//   rst               asynchronous active-low reset (clears memory and outputs)
//   din_a / din_b     write data, ports A / B
//   addr_a / addr_b   word address, ports A / B
//   we_a / we_b       write enables
//   re_a / re_b       read enables (registered read, 1-cycle latency, read-first)
//   dout_a / dout_b   registered read data, held while the read enable is low
//   collision         high for one cycle after both ports wrote the same address

`timescale 1ns/1ps

module dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk0,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din_a,
    input  logic [DATA_WIDTH-1:0] din_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic                  re_a,
    input  logic                  re_b,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  collision
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Same-address dual write: port A has priority, port B is dropped.
    logic same_addr_write;
    logic write_b_ok;

    always_comb begin
        same_addr_write = we_a && we_b && (addr_a == addr_b);
        write_b_ok      = we_b && !same_addr_write;
    end

    // Memory lives in flops so the whole array can be cleared by reset.
    // Reads sample mem before the non-blocking writes land, giving read-first
    // behaviour both on the same port and across ports.
    always_ff @(posedge clk0 or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            dout_a    <= '0;
            dout_b    <= '0;
            collision <= 1'b0;
        end else begin
            if (re_a) begin
                dout_a <= mem[addr_a];
            end
            if (re_b) begin
                dout_b <= mem[addr_b];
            end
            if (we_a) begin
                mem[addr_a] <= din_a;
            end
            if (write_b_ok) begin
                mem[addr_b] <= din_b;
            end
            collision <= same_addr_write;
        end
    end

endmodule

// File: tb/tb_dual_port_ram.sv
// tb/tb_dual_port_ram.sv - self-checking bench for dual_port_ram

`timescale 1ns/1ps

module tb_dual_port_ram;

    logic       clk0 = 1'b0;
    logic       rst  = 1'b0;
    logic [7:0] din_a = '0, din_b = '0;
    logic [3:0] addr_a = '0, addr_b = '0;
    logic       we_a = 1'b0, we_b = 1'b0, re_a = 1'b0, re_b = 1'b0;
    logic [7:0] dout_a, dout_b;
    logic       collision;

    int checks = 0;
    int errors = 0;

    dual_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk0      (clk0),
        .rst       (rst),
        .din_a     (din_a),
        .din_b     (din_b),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .we_a      (we_a),
        .we_b      (we_b),
        .re_a      (re_a),
        .re_b      (re_b),
        .dout_a    (dout_a),
        .dout_b    (dout_b),
        .collision (collision)
    );

    always #5 clk0 = ~clk0;

    // Reference model: storage array plus the values each output must show.
    logic [7:0] m_mem [16];
    logic [7:0] m_dout_a = '0, m_dout_b = '0;
    logic       m_coll = 1'b0;
    bit         cmp_en = 1'b0;

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
    end

    always @(posedge clk0 or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) m_mem[i] = '0;
            m_dout_a = '0;
            m_dout_b = '0;
            m_coll   = 1'b0;
        end else begin
            logic [7:0] old_a, old_b;
            old_a = m_mem[addr_a];
            old_b = m_mem[addr_b];
            if (re_a) m_dout_a = old_a;
            if (re_b) m_dout_b = old_b;
            m_coll = we_a && we_b && (addr_a == addr_b);
            if (we_a) m_mem[addr_a] = din_a;
            if (we_b && !(we_a && addr_a == addr_b)) m_mem[addr_b] = din_b;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk0) begin
        if (cmp_en) begin
            check("model dout_a", dout_a, m_dout_a);
            check("model dout_b", dout_b, m_dout_b);
            check("model collision", {7'b0, collision}, {7'b0, m_coll});
        end
    end

    // Apply one cycle of inputs at a falling edge, return at the next falling
    // edge when the registered outputs reflect that rising edge.
    task automatic drive(input logic wa, input logic ra, input logic [3:0] aa, input logic [7:0] da,
                         input logic wb, input logic rb, input logic [3:0] ab, input logic [7:0] db);
        we_a = wa; re_a = ra; addr_a = aa; din_a = da;
        we_b = wb; re_b = rb; addr_b = ab; din_b = db;
        @(negedge clk0);
    endtask

    task automatic idle();
        drive(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00);
    endtask

    logic [7:0] stream [10];

    initial begin
        stream = '{8'h01, 8'h03, 8'h07, 8'h1A, 8'h15, 8'h0A, 8'h7F, 8'h33, 8'hE3, 8'h69};

        // Reset state
        #2;
        check("reset dout_a", dout_a, 8'h00);
        check("reset dout_b", dout_b, 8'h00);
        check("reset collision", {7'b0, collision}, 8'h00);
        @(negedge clk0);
        rst = 1'b1;
        cmp_en = 1'b1;

        // Preload mem[3]=0x55, read it to both ports, then async reset mid-cycle
        drive(1, 0, 4'h3, 8'h55, 0, 0, 4'h0, 8'h00);
        drive(0, 1, 4'h3, 8'h00, 0, 1, 4'h3, 8'h00);
        check("preload dout_a", dout_a, 8'h55);
        check("preload dout_b", dout_b, 8'h55);
        idle();
        @(posedge clk0);
        #3 rst = 1'b0;
        #0.5;
        check("async reset dout_a", dout_a, 8'h00);
        check("async reset dout_b", dout_b, 8'h00);
        #0.5 rst = 1'b1;
        @(negedge clk0);
        drive(0, 1, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00);
        check("mem3 cleared", dout_a, 8'h00);

        // Streaming write on A while B keeps reading the untouched last word
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 4'hA, stream[i], 0, 1, 4'hF, 8'h00);
            check("stream dout_b F", dout_b, 8'h00);
        end
        drive(0, 0, 4'h0, 8'h00, 0, 1, 4'hA, 8'h00);
        check("stream last word", dout_b, 8'h69);

        // Cross-port read-during-write at the same address
        drive(1, 0, 4'h5, 8'h11, 0, 0, 4'h0, 8'h00);
        drive(1, 0, 4'h5, 8'h22, 0, 1, 4'h5, 8'h00);
        check("rdw old data", dout_b, 8'h11);
        drive(0, 0, 4'h0, 8'h00, 0, 1, 4'h5, 8'h00);
        check("rdw new data", dout_b, 8'h22);

        // Write collision at address 7: A wins, flag pulses one cycle
        drive(1, 0, 4'h7, 8'hAA, 1, 0, 4'h7, 8'hBB);
        check("collision set", {7'b0, collision}, 8'h01);
        drive(0, 0, 4'h0, 8'h00, 0, 1, 4'h7, 8'h00);
        check("collision clear", {7'b0, collision}, 8'h00);
        check("collision A wins", dout_b, 8'hAA);

        // Dual writes to different addresses, then crossed reads
        drive(1, 0, 4'h0, 8'h3C, 1, 0, 4'hF, 8'hC3);
        check("dual write no collision", {7'b0, collision}, 8'h00);
        drive(0, 1, 4'hF, 8'h00, 0, 1, 4'h0, 8'h00);
        check("cross read dout_a", dout_a, 8'hC3);
        check("cross read dout_b", dout_b, 8'h3C);

        // Hold while re_a is low, even as the word underneath changes
        drive(0, 0, 4'hF, 8'h00, 1, 0, 4'hF, 8'h99);
        check("hold dout_a", dout_a, 8'hC3);
        idle();
        check("hold dout_a 2", dout_a, 8'hC3);

        // Same-port read-first write
        drive(1, 1, 4'hF, 8'h44, 0, 0, 4'h0, 8'h00);
        check("same-port old data", dout_a, 8'h99);
        drive(0, 1, 4'hF, 8'h00, 0, 0, 4'h0, 8'h00);
        check("same-port new data", dout_a, 8'h44);

        idle();
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
